piso_serial_tx: RTL

Parallel-in serial-out transmitter that is the sending end of the single-wire serial link our SISO/SIPO shift-register chains consume. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock. It marks each data bit with a qualifier and flags the last bit of every word. Back-to-back words stream with no idle gap.

---
 rtl/piso_serial_tx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter: WIDTH-bit word in over valid/ready, MSB-first serial out.
// Define PISO_TX_PARITY_EN to append one even-parity bit to every frame.
module piso_serial_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             o,
  output logic             o_valid,
  output logic             o_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef PISO_TX_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state_r;
  logic [WIDTH-1:0] shift_reg_r;
  logic [CW-1:0]    cnt_r;
  logic             final_bit_s;
  logic             accept_s;

`ifdef PISO_TX_PARITY_EN
  logic par_r;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  // Final-bit detection, ready decode and handshake
  always_comb begin
    final_bit_s = 1'b0;
`ifdef PISO_TX_PARITY_EN
    if (state_r == PARITY) begin
      final_bit_s = 1'b1;
    end else begin
      final_bit_s = 1'b0;
    end
`else
    if ((state_r == SHIFT) && (cnt_r == '0)) begin
      final_bit_s = 1'b1;
    end else begin
      final_bit_s = 1'b0;
    end
`endif
    din_ready = (state_r == IDLE) | final_bit_s;
    accept_s  = din_valid & din_ready;
  end

  // State, shift register and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      shift_reg_r <= '0;
      cnt_r       <= '0;
`ifdef PISO_TX_PARITY_EN
      par_r       <= 1'b0;
`endif
    end else if (accept_s) begin
      state_r     <= SHIFT;
      shift_reg_r <= din;
      cnt_r       <= CNT_LOAD;
`ifdef PISO_TX_PARITY_EN
      par_r       <= even_parity(din);
`endif
    end else begin
      case (state_r)
        SHIFT: begin
          shift_reg_r <= {shift_reg_r[WIDTH-2:0], 1'b0};
          if (cnt_r == '0) begin
`ifdef PISO_TX_PARITY_EN
            state_r <= PARITY;
`else
            state_r <= IDLE;
`endif
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
`ifdef PISO_TX_PARITY_EN
        PARITY:  state_r <= IDLE;
`endif
        IDLE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Serial outputs decoded from registered state only
  always_comb begin
    o       = 1'b0;
    o_valid = 1'b0;
    o_last  = 1'b0;
    busy    = (state_r != IDLE);
    case (state_r)
      SHIFT: begin
        o       = shift_reg_r[WIDTH-1];
        o_valid = 1'b1;
`ifdef PISO_TX_PARITY_EN
        o_last  = 1'b0;
`else
        o_last  = (cnt_r == '0);
`endif
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        o       = par_r;
        o_valid = 1'b1;
        o_last  = 1'b1;
      end
`endif
      default: begin
        o       = 1'b0;
        o_valid = 1'b0;
        o_last  = 1'b0;
      end
    endcase
  end

endmodule
